// File: rtl/byte_mem_pkg.sv
// Shared types and constants for the byte bank and its stream reader.
package byte_mem_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] BYTE_RST = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/byte_regfile.sv
// DEPTH x BYTE_W byte bank: synchronous write, combinational read.
module byte_regfile
    import byte_mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem_r [DEPTH];

    // Storage update: clear on reset, otherwise write the addressed entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= BYTE_RST;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/byte_stream_reader.sv
// Streams entries 0..N-1 of a byte bank over valid/ready, then pulses done.
module byte_stream_reader
    import byte_mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              store,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    state_e            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W:0]   remaining_r;
    logic [ADDR_W-1:0] raddr_s;
    logic [BYTE_W-1:0] rdata_s;
    logic              xfer_s;

    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
        if (len > DEPTH_L) begin
            return DEPTH_L;
        end else begin
            return len;
        end
    endfunction

    byte_regfile #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .we    (store),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    assign xfer_s = out_valid && out_ready;

    // In SEND the next entry is prefetched so back-to-back transfers have no bubble.
    always_comb begin
        raddr_s = ptr_r;
        if (state_r == SEND) begin
            raddr_s = ptr_r + PTR_ONE;
        end else begin
            raddr_s = ptr_r;
        end
    end

    // Stream control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            ptr_r       <= PTR_ZERO;
            remaining_r <= LEN_ZERO;
            out_data    <= BYTE_RST;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (length == LEN_ZERO) begin
                            state_r <= FIN;
                            done    <= 1'b1;
                        end else begin
                            remaining_r <= clamp_len(length);
                            ptr_r       <= PTR_ZERO;
                            busy        <= 1'b1;
                            state_r     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    out_data  <= rdata_s;
                    out_valid <= 1'b1;
                    state_r   <= SEND;
                end
                SEND: begin
                    if (xfer_s) begin
                        if (remaining_r > REM_ONE) begin
                            ptr_r       <= ptr_r + PTR_ONE;
                            remaining_r <= remaining_r - REM_ONE;
                            out_data    <= rdata_s;
                        end else begin
                            remaining_r <= LEN_ZERO;
                            out_valid   <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state_r     <= FIN;
                        end
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
